frobenius_root_seq: RTL and testbench

- Sequential inverse of the combinational squaring chain: computes the 2^ROOT-th root of a CLM-encoded GF(2^M) element, i.e. y = x^(2^(M-ROOT)).
- Uses a single `square` instance, iterated ITER = (M - ROOT) mod M times over a state register.
- Draws fresh red_poly_t randomness on every iteration, so no reduction mask is reused across squarings.
- Sits between masked S-box/inversion stages that need square roots.
- Valid/ready on both sides.

---
 rtl/frobenius_root_seq_if.sv | 31 +++
 rtl/frobenius_root_seq.sv | 117 +++++++++++
 tb/tb_frobenius_root_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frobenius_root_seq_if.sv
// frobenius_root_seq_if: operand/result handshake bundle for the
// Frobenius root sequencer.
// master: drives in_valid/in/r/B_ext/out_ready; slave: drives
// in_ready/out_valid/out/busy.
interface frobenius_root_seq_if #(
   parameter int d = 2,
   parameter int M = 8
);
   localparam int W  = M + d;
   localparam int NR = 2 * W - 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in;
   logic [d-1:0]         r;
   logic [NR-1:0][M-1:0] B_ext;
   logic                 out_valid;
   logic                 out_ready;
   logic [W-1:0]         out;
   logic                 busy;

   modport master (
      output in_valid, in, r, B_ext, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, in, r, B_ext, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/frobenius_root_seq.sv
// frobenius_root_seq: 2^ROOT-th root of a CLM-encoded GF(2^M) element
// by ITER=(M-ROOT)%M masked squarings of one state register.
// Ports: clk, rst_n (async, active-low), bus (slave modport).
module square #(
   parameter int d = 2,
   parameter int M = 8
) (
   input  logic [M+d-1:0]              a_i,
   input  logic [d-1:0]                r_i,
   input  logic [2*(M+d)-2:0][M-1:0]   b_ext_i,
   output logic [M+d-1:0]              y_o
);
   localparam int W  = M + d;
   localparam int NR = 2 * W - 1;

   logic [NR-1:0] sq;
   logic [M-1:0]  red;
   logic [M:0]    p;
   logic [W-1:0]  rp;

   // Row i of b_ext_i is x^i mod P, so row M gives P = x^M + row M.
   // The fresh mask r*P keeps the decoded value but re-randomises
   // the redundant top bits.
   always_comb begin
      sq = '0;
      for (int i = 0; i < W; i++) begin
         sq[2*i] = a_i[i];
      end
      red = '0;
      for (int i = 0; i < NR; i++) begin
         if (sq[i]) red = red ^ b_ext_i[i];
      end
      p  = {1'b1, b_ext_i[M]};
      rp = '0;
      for (int j = 0; j < d; j++) begin
         if (r_i[j]) rp = rp ^ (W'(p) << j);
      end
      y_o = {{d{1'b0}}, red} ^ rp;
   end
endmodule

module frobenius_root_seq #(
   parameter int d    = 2,
   parameter int M    = 8,
   parameter int ROOT = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   frobenius_root_seq_if.slave bus
);
   localparam int ITER = (M - ROOT) % M;
   localparam int CW   = $clog2(M) + 1;
   localparam int W    = M + d;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  data_q, data_d;
   logic [W-1:0]  sq_y;
   logic [CW-1:0] cnt_q, cnt_d;
   // Holds in_ready low until the first edge after reset release.
   logic          rdy_q;

   square #(.d(d), .M(M)) u_sq (
      .a_i     (data_q),
      .r_i     (bus.r),
      .b_ext_i (bus.B_ext),
      .y_o     (sq_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      cnt_d         = cnt_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out       = '0;
      bus.busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = rdy_q;
            if (bus.in_valid && rdy_q) begin
               data_d  = bus.in;
               cnt_d   = CW'(ITER);
               state_d = (ITER != 0) ? RUN : DONE;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            data_d   = sq_y;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            bus.out       = data_q;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_frobenius_root_seq.sv
// tb_frobenius_root_seq: directed bench for frobenius_root_seq
// (ROOT=1 and ROOT=0 instances on shared clock/reset).
module tb_frobenius_root_seq;
   localparam int D  = 2;
   localparam int M  = 8;
   localparam int W  = M + D;
   localparam int NR = 2 * W - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   pass = 0;

   always #5 clk = ~clk;

   frobenius_root_seq_if #(.d(D), .M(M)) bus0 ();
   frobenius_root_seq_if #(.d(D), .M(M)) bus1 ();

   frobenius_root_seq #(.d(D), .M(M), .ROOT(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   frobenius_root_seq #(.d(D), .M(M), .ROOT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   function automatic logic [7:0] dec(input logic [W-1:0] e);
      logic [W-1:0] t;
      t = e;
      for (int i = W - 1; i >= M; i--)
         if (t[i]) t = t ^ (W'(9'h11B) << (i - M));
      return t[7:0];
   endfunction

   function automatic logic [7:0] gsq(input logic [7:0] a);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (a[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [W-1:0] enc(input logic [7:0] v, input logic [1:0] k);
      logic [W-1:0] e;
      e = W'(v);
      if (k[0]) e = e ^ W'(9'h11B);
      if (k[1]) e = e ^ (W'(9'h11B) << 1);
      return e;
   endfunction

   function automatic logic [1:0] pick(input int rm);
      return (rm == 0) ? 2'($urandom) : 2'(rm);
   endfunction

   task automatic run0(input logic [W-1:0] e, input int rm,
                       output logic [W-1:0] res, output int lat);
      bus0.in = e;
      bus0.in_valid = 1'b1;
      bus0.r = pick(rm);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      lat = 0;
      while (!bus0.out_valid && lat < 20) begin
         bus0.r = pick(rm);
         @(negedge clk);
         lat++;
      end
      res = bus0.out;
      bus0.out_ready = 1'b1;
      @(negedge clk);
      bus0.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      total++; if (bus0.out_valid !== 1'b0) $display("FAIL rst_ovalid got=%0b exp=0", bus0.out_valid); else pass++;
      total++; if (bus0.out !== '0) $display("FAIL rst_out got=%0h exp=0", bus0.out); else pass++;
      total++; if (bus0.busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", bus0.busy); else pass++;
      total++; if (bus0.in_ready !== 1'b0) $display("FAIL rst_iready got=%0b exp=0", bus0.in_ready); else pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (bus0.in_ready !== 1'b0) $display("FAIL rst_iready_rel got=%0b exp=0", bus0.in_ready); else pass++;
      @(negedge clk);
      total++; if (bus0.in_ready !== 1'b1) $display("FAIL rst_iready_edge got=%0b exp=1", bus0.in_ready); else pass++;
      total++; if (bus1.in_ready !== 1'b1) $display("FAIL rst_iready_r0 got=%0b exp=1", bus1.in_ready); else pass++;
   endtask

   task automatic test_sweep;
      logic [W-1:0] res;
      int lat;
      logic [7:0] y;
      for (int v = 0; v < 256; v++) begin
         run0(enc(8'(v), 2'($urandom)), 0, res, lat);
         y = dec(res);
         total++; if (lat != 7) $display("FAIL sweep_lat v=%0h got=%0d exp=7", v, lat); else pass++;
         total++; if (gsq(y) !== 8'(v)) $display("FAIL sweep_root v=%0h got=%0h exp=%0h", v, gsq(y), v); else pass++;
         total++; if (bus0.out !== '0 || bus0.out_valid !== 1'b0) $display("FAIL sweep_idle_out v=%0h got=%0h exp=0", v, bus0.out); else pass++;
      end
      run0(enc(8'h00, 2'd1), 0, res, lat);
      total++; if (dec(res) !== 8'h00) $display("FAIL fix_zero got=%0h exp=0", dec(res)); else pass++;
      run0(enc(8'h01, 2'd2), 0, res, lat);
      total++; if (dec(res) !== 8'h01) $display("FAIL fix_one got=%0h exp=1", dec(res)); else pass++;
   endtask

   task automatic test_root0;
      logic [W-1:0] e;
      e = enc(8'h53, 2'd3);
      bus1.in = e;
      bus1.in_valid = 1'b1;
      bus1.r = 2'd1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      total++; if (bus1.out_valid !== 1'b1) $display("FAIL r0_ovalid got=%0b exp=1", bus1.out_valid); else pass++;
      total++; if (dec(bus1.out) !== 8'h53) $display("FAIL r0_value got=%0h exp=53", dec(bus1.out)); else pass++;
      total++; if (bus1.out !== e) $display("FAIL r0_enc got=%0h exp=%0h", bus1.out, e); else pass++;
      bus1.r = 2'd2;
      @(negedge clk);
      total++; if (bus1.out !== e) $display("FAIL r0_hold got=%0h exp=%0h", bus1.out, e); else pass++;
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      total++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) $display("FAIL r0_idle got=%0b%0b exp=01", bus1.out_valid, bus1.in_ready); else pass++;
   endtask

   task automatic test_backpressure;
      logic [W-1:0] held;
      int lat;
      bus0.in = enc(8'h37, 2'd1);
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      lat = 0;
      while (!bus0.out_valid && lat < 20) begin
         bus0.r = 2'($urandom);
         @(negedge clk);
         lat++;
      end
      total++; if (lat != 7) $display("FAIL bp_lat got=%0d exp=7", lat); else pass++;
      held = bus0.out;
      total++; if (gsq(dec(held)) !== 8'h37) $display("FAIL bp_root got=%0h exp=37", gsq(dec(held))); else pass++;
      for (int i = 0; i < 10; i++) begin
         bus0.r = 2'($urandom);
         bus0.in = W'($urandom);
         bus0.in_valid = 1'b1;
         @(negedge clk);
         total++;
         if ({bus0.out_valid, bus0.in_ready, bus0.out} !== {1'b1, 1'b0, held})
            $display("FAIL bp_hold c=%0d got=%0b/%0b/%0h exp=1/0/%0h", i, bus0.out_valid, bus0.in_ready, bus0.out, held);
         else pass++;
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      @(negedge clk);
      bus0.out_ready = 1'b0;
      total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) $display("FAIL bp_release got=%0b%0b exp=01", bus0.out_valid, bus0.in_ready); else pass++;
      @(negedge clk);
      total++; if (bus0.busy !== 1'b0) $display("FAIL bp_nocapture got=%0b exp=0", bus0.busy); else pass++;
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals [4];
      logic [W-1:0] encs [4];
      logic [W-1:0] res [4];
      int acc_cyc [4];
      int na, nr, cyc;
      logic acc;
      vals = '{8'h11, 8'h80, 8'hFE, 8'h02};
      for (int i = 0; i < 4; i++) encs[i] = enc(vals[i], 2'(i));
      na = 0; nr = 0; cyc = 0;
      bus0.out_ready = 1'b1;
      while (nr < 4 && cyc < 100) begin
         bus0.in_valid = (na < 4);
         bus0.in = (na < 4) ? encs[na] : '0;
         bus0.r = 2'($urandom);
         if (bus0.out_valid) begin
            res[nr] = bus0.out;
            nr++;
         end
         acc = bus0.in_ready && bus0.in_valid;
         @(negedge clk);
         cyc++;
         if (acc) begin
            acc_cyc[na] = cyc;
            na++;
         end
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b0;
      @(negedge clk);
      total++; if (nr != 4) $display("FAIL b2b_count got=%0d exp=4", nr); else pass++;
      for (int j = 0; j < 4; j++) begin
         if (j < nr) begin
            total++; if (gsq(dec(res[j])) !== vals[j]) $display("FAIL b2b_root j=%0d got=%0h exp=%0h", j, gsq(dec(res[j])), vals[j]); else pass++;
         end
         if (j > 0 && j < na) begin
            total++; if (acc_cyc[j] - acc_cyc[j-1] != 9) $display("FAIL b2b_ii j=%0d got=%0d exp=9", j, acc_cyc[j] - acc_cyc[j-1]); else pass++;
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] res;
      int lat;
      bus0.in = enc(8'hC3, 2'd2);
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      repeat (3) begin
         bus0.r = 2'($urandom);
         @(negedge clk);
      end
      total++; if (bus0.busy !== 1'b1) $display("FAIL mid_busy_pre got=%0b exp=1", bus0.busy); else pass++;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({bus0.out_valid, bus0.busy, bus0.in_ready, bus0.out} !== {3'b000, W'(0)})
         $display("FAIL mid_async got=%0b%0b%0b/%0h exp=000/0", bus0.out_valid, bus0.busy, bus0.in_ready, bus0.out);
      else pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (bus0.in_ready !== 1'b0) $display("FAIL mid_iready_rel got=%0b exp=0", bus0.in_ready); else pass++;
      @(negedge clk);
      total++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) $display("FAIL mid_iready_edge got=%0b%0b exp=10", bus0.in_ready, bus0.out_valid); else pass++;
      run0(enc(8'hA5, 2'd3), 0, res, lat);
      total++; if (lat != 7) $display("FAIL mid_lat got=%0d exp=7", lat); else pass++;
      total++; if (gsq(dec(res)) !== 8'hA5) $display("FAIL mid_root got=%0h exp=a5", gsq(dec(res))); else pass++;
   endtask

   task automatic test_rand_indep;
      logic [W-1:0] ra, rb;
      int lat;
      run0(enc(8'h02, 2'd0), 1, ra, lat);
      run0(enc(8'h02, 2'd0), 2, rb, lat);
      total++; if (ra === rb) $display("FAIL indep_enc got=%0h exp!=%0h", rb, ra); else pass++;
      total++; if (gsq(dec(ra)) !== 8'h02) $display("FAIL indep_a got=%0h exp=02", gsq(dec(ra))); else pass++;
      total++; if (gsq(dec(rb)) !== 8'h02) $display("FAIL indep_b got=%0h exp=02", gsq(dec(rb))); else pass++;
   endtask

   initial begin
      logic [8:0] t;
      bus0.in_valid = 1'b0; bus0.in = '0; bus0.r = '0; bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in = '0; bus1.r = '0; bus1.out_ready = 1'b0;
      t = 9'h001;
      for (int i = 0; i < NR; i++) begin
         bus0.B_ext[i] = t[7:0];
         bus1.B_ext[i] = t[7:0];
         t = t << 1;
         if (t[8]) t = t ^ 9'h11B;
      end
      test_reset();
      test_sweep();
      test_root0();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_rand_indep();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired passed=%0d total=%0d", pass, total);
      $fatal(1);
   end
endmodule
